// File: rtl/savestate_ddr_bridge_if.sv
// savestate_ddr_bridge_if
// Groups the two bus ports of the save-state bridge.
//   mem_*    : byte-wide core RAM port (mem_din valid the cycle after mem_rd)
//   DDRAM_*  : 64-bit DDR word port with BUSY back-pressure and read return
// Modports:
//   master : the bridge (drives RAM strobes and DDR commands)
//   slave  : RAM / DDR side (returns read data, BUSY, DOUT_READY)
interface savestate_ddr_bridge_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_din;
  logic        mem_wr;
  logic [7:0]  mem_dout;

  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic        DDRAM_RD;
  logic        DDRAM_WE;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_dout,
    input  mem_din,
    output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE,
    input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_dout,
    output mem_din,
    input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE,
    output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY
  );
endinterface

// File: rtl/savestate_ddr_bridge.sv
// savestate_ddr_bridge
// Copies the 64 KiB core RAM to / from one of four DDR save slots.
// Save: 8 RAM byte reads are packed into one 64-bit DDR word write.
// Load: one DDR word read is unpacked into 8 RAM byte writes.
// Ports:
//   clk_sys, reset (async, active-high)
//   save_state / load_state : level requests, acted on at rising edge in IDLE
//   ss_slot                 : slot select, sampled with the accepted edge
//   bus (master)            : core RAM port + DDRAM port
//   cpu_halt, busy          : high while a transfer is in progress
//   done                    : one-cycle pulse at the end of a transfer
//   error                   : header mismatch on load, sticky until next request
// Parameters:
//   WORDS : 64-bit words per transfer (8192 = full 64 KiB)
// Build option:
//   SS_HEADER_EN : write / verify a one-word header ahead of the data
module savestate_ddr_bridge #(
  parameter int unsigned WORDS = 8192
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          save_state,
  input  logic                          load_state,
  input  logic [1:0]                    ss_slot,
  savestate_ddr_bridge_if.master        bus,
  output logic                          cpu_halt,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam logic [28:0] SLOT_BASE = 29'h0600_0000;
  localparam logic [12:0] LAST_WORD = 13'(WORDS - 1);
`ifdef SS_HEADER_EN
  localparam logic [63:0] HDR_WORD  = {32'h5452_5338, 16'h0001, 16'h2000};
  localparam logic [28:0] DATA_OFF  = 29'd1;
`else
  localparam logic [28:0] DATA_OFF  = 29'd0;
`endif

  typedef enum logic [3:0] {
    IDLE, HDR_WR, MEM_RD, DDR_WR, HDR_RD, HDR_CHK, DDR_RD, MEM_WR, FINISH
  } state_t;

  state_t           state_q;
  logic             save_prev_q, load_prev_q;
  logic [28:0]      base_q;
  logic [12:0]      word_q;
  logic [3:0]       byte_q;
  logic [15:0]      mem_addr_q;
  logic             mem_rd_q, mem_wr_q;
  logic [7:0]       mem_dout_q;
  logic             rd_vld_q;
  logic [2:0]       rd_idx_q;
  logic [28:0]      ddr_addr_q;
  logic             ddr_rd_q, ddr_we_q;
  logic [7:0][7:0]  din_q;
  logic [7:0][7:0]  rbuf_q;
  logic             busy_q, done_q, error_q;

  logic             save_rise, load_rise;
  logic [28:0]      slot_base_d;
  logic [12:0]      word_nxt_d;

  assign save_rise   = save_state & ~save_prev_q;
  assign load_rise   = load_state & ~load_prev_q;
  assign slot_base_d = SLOT_BASE + 29'({ss_slot, 17'd0});
  assign word_nxt_d  = word_q + 13'd1;

  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_wr         = mem_wr_q;
  assign bus.mem_dout       = mem_dout_q;
  assign bus.DDRAM_BURSTCNT = 8'd1;
  assign bus.DDRAM_ADDR     = ddr_addr_q;
  assign bus.DDRAM_RD       = ddr_rd_q;
  assign bus.DDRAM_WE       = ddr_we_q;
  assign bus.DDRAM_DIN      = din_q;
  assign bus.DDRAM_BE       = 8'hFF;
  assign cpu_halt           = busy_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      // Start "high" so a request level held through reset is not an edge.
      save_prev_q <= 1'b1;
      load_prev_q <= 1'b1;
      base_q      <= '0;
      word_q      <= '0;
      byte_q      <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_dout_q  <= '0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      ddr_addr_q  <= '0;
      ddr_rd_q    <= 1'b0;
      ddr_we_q    <= 1'b0;
      din_q       <= '0;
      rbuf_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      save_prev_q <= save_state;
      load_prev_q <= load_state;
      // RAM read data returns one cycle after the strobe; track which byte.
      rd_vld_q    <= mem_rd_q;
      rd_idx_q    <= mem_addr_q[2:0];

      case (state_q)
        IDLE: begin
          if (save_rise) begin
            base_q  <= slot_base_d;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            word_q  <= '0;
            byte_q  <= '0;
`ifdef SS_HEADER_EN
            ddr_we_q   <= 1'b1;
            ddr_addr_q <= slot_base_d;
            din_q      <= HDR_WORD;
            state_q    <= HDR_WR;
`else
            state_q    <= MEM_RD;
`endif
          end else if (load_rise) begin
            base_q     <= slot_base_d;
            busy_q     <= 1'b1;
            error_q    <= 1'b0;
            word_q     <= '0;
            byte_q     <= '0;
            ddr_rd_q   <= 1'b1;
            ddr_addr_q <= slot_base_d;
`ifdef SS_HEADER_EN
            state_q    <= HDR_RD;
`else
            state_q    <= DDR_RD;
`endif
          end
        end

`ifdef SS_HEADER_EN
        HDR_WR: begin
          if (!bus.DDRAM_BUSY) begin
            ddr_we_q <= 1'b0;
            byte_q   <= '0;
            state_q  <= MEM_RD;
          end
        end

        HDR_RD: begin
          if (ddr_rd_q) begin
            if (!bus.DDRAM_BUSY) ddr_rd_q <= 1'b0;
          end else if (bus.DDRAM_DOUT_READY) begin
            rbuf_q  <= bus.DDRAM_DOUT;
            state_q <= HDR_CHK;
          end
        end

        HDR_CHK: begin
          if (rbuf_q == HDR_WORD) begin
            ddr_rd_q   <= 1'b1;
            ddr_addr_q <= base_q + DATA_OFF;
            state_q    <= DDR_RD;
          end else begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
`endif

        // byte_q 0..7 issue reads, 8 drains the last return, 9 hands off
        // the packed word to the DDR write.
        MEM_RD: begin
          if (rd_vld_q) din_q[rd_idx_q] <= bus.mem_din;
          if (!byte_q[3]) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= {word_q, byte_q[2:0]};
            byte_q     <= byte_q + 4'd1;
          end else if (byte_q == 4'd8) begin
            mem_rd_q <= 1'b0;
            byte_q   <= 4'd9;
          end else begin
            ddr_we_q   <= 1'b1;
            ddr_addr_q <= base_q + DATA_OFF + 29'(word_q);
            state_q    <= DDR_WR;
          end
        end

        DDR_WR: begin
          if (!bus.DDRAM_BUSY) begin
            ddr_we_q <= 1'b0;
            if (word_q == LAST_WORD) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              word_q  <= word_nxt_d;
              byte_q  <= '0;
              state_q <= MEM_RD;
            end
          end
        end

        DDR_RD: begin
          if (ddr_rd_q) begin
            if (!bus.DDRAM_BUSY) ddr_rd_q <= 1'b0;
          end else if (bus.DDRAM_DOUT_READY) begin
            rbuf_q  <= bus.DDRAM_DOUT;
            byte_q  <= '0;
            state_q <= MEM_WR;
          end
        end

        MEM_WR: begin
          if (!byte_q[3]) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= {word_q, byte_q[2:0]};
            mem_dout_q <= rbuf_q[byte_q[2:0]];
            byte_q     <= byte_q + 4'd1;
          end else begin
            mem_wr_q <= 1'b0;
            if (word_q == LAST_WORD) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              word_q     <= word_nxt_d;
              ddr_rd_q   <= 1'b1;
              ddr_addr_q <= base_q + DATA_OFF + 29'(word_nxt_d);
              state_q    <= DDR_RD;
            end
          end
        end

        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_savestate_ddr_bridge.sv
module tb_savestate_ddr_bridge;
  localparam int NW = 64;
`ifdef SS_HEADER_EN
  localparam int HOFF = 1;
`else
  localparam int HOFF = 0;
`endif
  localparam logic [63:0] HDR = 64'h5452_5338_0001_2000;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       save_state = 1'b0;
  logic       load_state = 1'b0;
  logic [1:0] ss_slot = 2'd0;
  logic       cpu_halt, busy, done, error;

  savestate_ddr_bridge_if bus();

  savestate_ddr_bridge #(.WORDS(NW)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .save_state (save_state),
    .load_state (load_state),
    .ss_slot    (ss_slot),
    .bus        (bus),
    .cpu_halt   (cpu_halt),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { logic [28:0] a; logic [63:0] d; } dw_t;
  typedef struct { logic [15:0] a; logic [7:0]  d; } mw_t;
  dw_t ddr_exp[$];
  mw_t mem_exp[$];

  logic [7:0]  ram [0:65535];
  logic [63:0] ddr_mem [logic [28:0]];

  int n_cmp = 0, n_err = 0;
  int wr_cnt = 0, rd_cnt = 0, mwr_cnt = 0, done_cnt = 0;

  bit          fill_req = 0;
  int          fill_pat = 0;
  bit          pre_req = 0;
  logic [28:0] pre_base = '0;
  int          pre_pat = 0, pre_nw = 0;
  logic [63:0] pre_hdr = '0;
  bit          stall_en = 0;

  function automatic logic [7:0] pat(int a, int p);
    case (p)
      0:       return 8'(a);
      1:       return 8'(a) ^ 8'h5A;
      2:       return 8'(a * 3 + 7);
      default: return ~8'(a);
    endcase
  endfunction

  function automatic logic [63:0] word_of(int k, int p);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = pat(8*k + i, p);
    return w;
  endfunction

  function automatic logic [28:0] sbase(int s);
    return 29'h0600_0000 + 29'(s) * 29'h0002_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // RAM model: read data one cycle after mem_rd, write on mem_wr.
  initial begin
    bus.mem_din = '0;
    forever begin
      @(posedge clk_sys);
      if (fill_req) begin
        for (int i = 0; i < 65536; i++) ram[i] <= pat(i, fill_pat);
      end else if (bus.mem_wr) begin
        ram[bus.mem_addr] <= bus.mem_dout;
      end
      if (bus.mem_rd) bus.mem_din <= ram[bus.mem_addr];
    end
  end

  // DDR model + scoreboard monitor, evaluated on the falling edge.
  initial begin
    int          stall_left;
    int          rd_dly;
    bit          in_cmd;
    logic [28:0] snap_addr, rd_addr;
    logic [63:0] snap_din;
    logic [1:0]  snap_cmd;
    stall_left = 0; rd_dly = 0; in_cmd = 0; rd_addr = '0;
    snap_addr = '0; snap_din = '0; snap_cmd = '0;
    bus.DDRAM_BUSY = 1'b0;
    bus.DDRAM_DOUT = '0;
    bus.DDRAM_DOUT_READY = 1'b0;
    forever begin
      @(negedge clk_sys);
      bus.DDRAM_DOUT_READY = 1'b0;
      if (pre_req) begin
        if (HOFF != 0) ddr_mem[pre_base] = pre_hdr;
        for (int k = 0; k < pre_nw; k++)
          ddr_mem[pre_base + 29'(HOFF) + 29'(k)] = word_of(k, pre_pat);
      end
      if (done) done_cnt++;
      if (reset) begin
        bus.DDRAM_BUSY = 1'b0;
        stall_left = 0; rd_dly = 0; in_cmd = 0;
      end else begin
        if (bus.mem_wr) begin
          mwr_cnt++;
          if (mem_exp.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL mem_wr_unexpected: got addr %h data %h", bus.mem_addr, bus.mem_dout);
          end else begin
            mw_t e;
            e = mem_exp.pop_front();
            chk("mem_wr_addr", 64'(bus.mem_addr), 64'(e.a));
            chk("mem_wr_data", 64'(bus.mem_dout), 64'(e.d));
          end
        end
        if (rd_dly > 0) begin
          rd_dly--;
          if (rd_dly == 0) begin
            bus.DDRAM_DOUT = ddr_mem.exists(rd_addr) ? ddr_mem[rd_addr] : 64'h0;
            bus.DDRAM_DOUT_READY = 1'b1;
          end
        end
        if (bus.DDRAM_WE || bus.DDRAM_RD) begin
          if (!in_cmd) begin
            in_cmd = 1;
            snap_addr = bus.DDRAM_ADDR;
            snap_din = bus.DDRAM_DIN;
            snap_cmd = {bus.DDRAM_WE, bus.DDRAM_RD};
            stall_left = stall_en ? 5 : 0;
          end else begin
            chk("stall_cmd", 64'({bus.DDRAM_WE, bus.DDRAM_RD}), 64'(snap_cmd));
            chk("stall_addr", 64'(bus.DDRAM_ADDR), 64'(snap_addr));
            chk("stall_din", bus.DDRAM_DIN, snap_din);
          end
          if (stall_left > 0) begin
            bus.DDRAM_BUSY = 1'b1;
            stall_left--;
          end else begin
            bus.DDRAM_BUSY = 1'b0;
            in_cmd = 0;
            if (bus.DDRAM_WE) begin
              wr_cnt++;
              ddr_mem[bus.DDRAM_ADDR] = bus.DDRAM_DIN;
              if (ddr_exp.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL ddr_wr_unexpected: got addr %h data %h", bus.DDRAM_ADDR, bus.DDRAM_DIN);
              end else begin
                dw_t e;
                e = ddr_exp.pop_front();
                chk("ddr_wr_addr", 64'(bus.DDRAM_ADDR), 64'(e.a));
                chk("ddr_wr_data", bus.DDRAM_DIN, e.d);
              end
            end else begin
              rd_cnt++;
              chk("rd_outstanding", 64'(rd_dly), 64'd0);
              rd_addr = bus.DDRAM_ADDR;
              rd_dly = 2;
            end
          end
        end else begin
          bus.DDRAM_BUSY = 1'b0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of run, required finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic fill(input int p);
    fill_pat = p;
    fill_req = 1;
    tick(1);
    fill_req = 0;
  endtask

  task automatic preload(input int s, input int p, input int nw, input logic [63:0] h);
    pre_base = sbase(s); pre_pat = p; pre_nw = nw; pre_hdr = h;
    pre_req = 1;
    @(negedge clk_sys);
    tick(1);
    pre_req = 0;
  endtask

  task automatic push_save(input int s, input int p);
    if (HOFF != 0) ddr_exp.push_back('{a: sbase(s), d: HDR});
    for (int k = 0; k < NW; k++)
      ddr_exp.push_back('{a: sbase(s) + 29'(HOFF) + 29'(k), d: word_of(k, p)});
  endtask

  task automatic push_load(input int p);
    for (int k = 0; k < NW; k++)
      for (int i = 0; i < 8; i++)
        mem_exp.push_back('{a: 16'(8*k + i), d: pat(8*k + i, p)});
  endtask

  task automatic pulse_save(input int s);
    ss_slot = 2'(s);
    save_state = 1;
    tick(3);
    save_state = 0;
  endtask

  task automatic pulse_load(input int s);
    ss_slot = 2'(s);
    load_state = 1;
    tick(3);
    load_state = 0;
  endtask

  task automatic wait_done(input string nm, input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      tick(1);
      t++;
    end
    chk({nm, "_timeout"}, 64'(t >= 20000), 64'd0);
    tick(3);
    chk({nm, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_halt_after"}, 64'({cpu_halt, busy}), 64'd0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ctl"}, 64'({bus.mem_rd, bus.mem_wr, bus.DDRAM_RD, bus.DDRAM_WE,
                           cpu_halt, busy, done, error}), 64'd0);
    chk({nm, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({nm, "_mem_dout"}, 64'(bus.mem_dout), 64'd0);
    chk({nm, "_ddr_addr"}, 64'(bus.DDRAM_ADDR), 64'd0);
    chk({nm, "_ddr_din"}, bus.DDRAM_DIN, 64'd0);
    chk({nm, "_be"}, 64'(bus.DDRAM_BE), 64'hFF);
    chk({nm, "_burst"}, 64'(bus.DDRAM_BURSTCNT), 64'd1);
  endtask

  task automatic chk_ram(input string nm, input int p);
    int bad;
    bad = 0;
    for (int i = 0; i < NW * 8; i++) if (ram[i] !== pat(i, p)) bad++;
    chk(nm, 64'(bad), 64'd0);
  endtask

  initial begin
    int w0, r0, m0, d0, t;

    // Reset state
    tick(3);
    chk_reset_outs("rst");
    reset = 0;
    tick(2);
    chk("idle_after_rst", 64'({cpu_halt, busy, done}), 64'd0);

    // Save slot 2, RAM[i] = i
    fill(0);
    push_save(2, 0);
    w0 = wr_cnt; m0 = mwr_cnt; d0 = done_cnt;
    pulse_save(2);
    wait_done("save2", d0);
    chk("save2_writes", 64'(wr_cnt - w0), 64'(NW + HOFF));
    chk("save2_word0", ddr_mem[29'h0604_0000 + 29'(HOFF)], 64'h0706_0504_0302_0100);
    chk("save2_sb_empty", 64'(ddr_exp.size()), 64'd0);
    chk("save2_no_memwr", 64'(mwr_cnt - m0), 64'd0);
    chk("save2_error", 64'(error), 64'd0);

    // Load slot 0 from a preloaded image
    preload(0, 2, NW, HDR);
    fill(3);
    push_load(2);
    r0 = rd_cnt; m0 = mwr_cnt; d0 = done_cnt;
    pulse_load(0);
    wait_done("load0", d0);
    chk("load0_memwr", 64'(mwr_cnt - m0), 64'(NW * 8));
    chk("load0_reads", 64'(rd_cnt - r0), 64'(NW + HOFF));
    chk_ram("load0_ram", 2);
    chk("load0_sb_empty", 64'(mem_exp.size()), 64'd0);
    chk("load0_error", 64'(error), 64'd0);

    // BUSY stalls on every command: save slot 1 then load it back
    stall_en = 1;
    fill(1);
    push_save(1, 1);
    w0 = wr_cnt; d0 = done_cnt;
    pulse_save(1);
    wait_done("stall_save", d0);
    chk("stall_save_writes", 64'(wr_cnt - w0), 64'(NW + HOFF));
    chk("stall_save_sb_empty", 64'(ddr_exp.size()), 64'd0);
    fill(3);
    push_load(1);
    m0 = mwr_cnt; d0 = done_cnt;
    pulse_load(1);
    wait_done("stall_load", d0);
    chk("stall_load_memwr", 64'(mwr_cnt - m0), 64'(NW * 8));
    chk_ram("stall_load_ram", 1);
    stall_en = 0;

`ifdef SS_HEADER_EN
    // Bad header on slot 1: error, done, no RAM writes
    preload(1, 0, 0, 64'h0);
    m0 = mwr_cnt; d0 = done_cnt;
    pulse_load(1);
    wait_done("badhdr", d0);
    chk("badhdr_error", 64'(error), 64'd1);
    chk("badhdr_memwr", 64'(mwr_cnt - m0), 64'd0);
`endif

    // Simultaneous rise: save wins; load toggled mid-save ignored
    fill(0);
    push_save(3, 0);
    w0 = wr_cnt; r0 = rd_cnt; m0 = mwr_cnt; d0 = done_cnt;
    ss_slot = 2'd3;
    save_state = 1;
    load_state = 1;
    tick(3);
    save_state = 0;
    load_state = 0;
    tick(20);
    load_state = 1;
    tick(2);
    load_state = 0;
    wait_done("both", d0);
    chk("both_writes", 64'(wr_cnt - w0), 64'(NW + HOFF));
    chk("both_no_reads", 64'(rd_cnt - r0), 64'd0);
    chk("both_no_memwr", 64'(mwr_cnt - m0), 64'd0);
    chk("both_error", 64'(error), 64'd0);

    // Reset in the middle of a save, request level held through reset
    push_save(0, 0);
    w0 = wr_cnt;
    ss_slot = 2'd0;
    save_state = 1;
    t = 0;
    while (wr_cnt - w0 < 10 && t < 2000) begin
      tick(1);
      t++;
    end
    chk("midrst_reach", 64'(t >= 2000), 64'd0);
    reset = 1;
    ddr_exp.delete();
    tick(1);
    chk_reset_outs("midrst");
    tick(2);
    reset = 0;
    w0 = wr_cnt;
    tick(20);
    chk("held_level_no_start", 64'({busy, cpu_halt}), 64'd0);
    chk("held_level_no_wr", 64'(wr_cnt - w0), 64'd0);
    save_state = 0;
    tick(2);
    push_save(0, 0);
    w0 = wr_cnt; d0 = done_cnt;
    pulse_save(0);
    wait_done("resave", d0);
    chk("resave_writes", 64'(wr_cnt - w0), 64'(NW + HOFF));
    chk("resave_sb_empty", 64'(ddr_exp.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
